// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: bundle of the two requester ports and the SRAM controller request port.
// Requester A and B: req_*, write_*, addr_*, wdata_* in; ack_* out.
// Shared response to requesters: rdata, err, busy.
// SRAM controller side: address, wdata, valid_request and write out; sram_rdata and valid_read in.
// Modport slave is the arbiter. Modport master is the environment, meaning the requesters and the SRAM controller.
interface sram_arbiter_if;
    logic        req_a;
    logic        write_a;
    logic [21:0] addr_a;
    logic [15:0] wdata_a;
    logic        ack_a;
    logic        req_b;
    logic        write_b;
    logic [21:0] addr_b;
    logic [15:0] wdata_b;
    logic        ack_b;
    logic [15:0] rdata;
    logic        err;
    logic        busy;
    logic [21:0] address;
    logic [15:0] wdata;
    logic        valid_request;
    logic        write;
    logic [15:0] sram_rdata;
    logic        valid_read;

    modport slave (
        input  req_a, write_a, addr_a, wdata_a,
        input  req_b, write_b, addr_b, wdata_b,
        input  sram_rdata, valid_read,
        output ack_a, ack_b, rdata, err, busy,
        output address, wdata, valid_request, write
    );

    modport master (
        output req_a, write_a, addr_a, wdata_a,
        output req_b, write_b, addr_b, wdata_b,
        output sram_rdata, valid_read,
        input  ack_a, ack_b, rdata, err, busy,
        input  address, wdata, valid_request, write
    );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin two-port arbiter that sequences single-word reads and writes into the SRAM controller.
// clk   : system clock; all logic runs on the rising edge.
// rst_n : asynchronous, active-low reset.
// bus   : sram_arbiter_if.slave, carrying the requester A/B ports, the acknowledge/response, and the SRAM controller port.
// WR_CYCLES  : cycles from write issue to write completion (1..255).
// RD_TIMEOUT : maximum cycles spent waiting for valid_read before an error response (2..255).
module sram_arbiter #(
    parameter int WR_CYCLES  = 4,
    parameter int RD_TIMEOUT = 64
) (
    input logic           clk,
    input logic           rst_n,
    sram_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RD, WAIT_WR, RESP} state_t;

    localparam logic [7:0] WR_LAST = 8'(WR_CYCLES - 1);
    localparam logic [7:0] RD_LAST = 8'(RD_TIMEOUT - 1);

    state_t     state;
    logic [7:0] cnt;
    logic       last_b;
    logic       gnt_b;
    logic       grant_a;
    logic       grant_b;

    // A wins a tie unless A was the last grant. The pointer resets to B, so A wins the first tie.
    assign grant_a = bus.req_a && (!bus.req_b || last_b);
    assign grant_b = bus.req_b && !grant_a;

    // The address, wdata and write outputs are the latch registers for the granted request.
    // They hold from ISSUE through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            cnt               <= 8'd0;
            last_b            <= 1'b1;
            gnt_b             <= 1'b0;
            bus.ack_a         <= 1'b0;
            bus.ack_b         <= 1'b0;
            bus.rdata         <= 16'd0;
            bus.err           <= 1'b0;
            bus.busy          <= 1'b0;
            bus.address       <= 22'd0;
            bus.wdata         <= 16'd0;
            bus.valid_request <= 1'b0;
            bus.write         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_a || grant_b) begin
                        gnt_b             <= grant_b;
                        last_b            <= grant_b;
                        bus.write         <= grant_b ? bus.write_b : bus.write_a;
                        bus.address       <= grant_b ? bus.addr_b  : bus.addr_a;
                        bus.wdata         <= grant_b ? bus.wdata_b : bus.wdata_a;
                        bus.valid_request <= 1'b1;
                        bus.busy          <= 1'b1;
                        state             <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.valid_request <= 1'b0;
                    cnt               <= 8'd0;
                    state             <= bus.write ? WAIT_WR : WAIT_RD;
                end
                WAIT_RD: begin
                    cnt <= cnt + 8'd1;
                    // Returned data takes priority over a timeout that falls in the same cycle.
                    if (bus.valid_read) begin
                        bus.rdata <= bus.sram_rdata;
                        bus.err   <= 1'b0;
                        bus.ack_a <= !gnt_b;
                        bus.ack_b <= gnt_b;
                        state     <= RESP;
                    end else if (cnt == RD_LAST) begin
                        bus.rdata <= 16'd0;
                        bus.err   <= 1'b1;
                        bus.ack_a <= !gnt_b;
                        bus.ack_b <= gnt_b;
                        state     <= RESP;
                    end
                end
                WAIT_WR: begin
                    cnt <= cnt + 8'd1;
                    if (cnt == WR_LAST) begin
                        bus.err   <= 1'b0;
                        bus.ack_a <= !gnt_b;
                        bus.ack_b <= gnt_b;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    bus.ack_a <= 1'b0;
                    bus.ack_b <= 1'b0;
                    bus.err   <= 1'b0;
                    bus.busy  <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: scoreboard testbench for sram_arbiter (WR_CYCLES=4, RD_TIMEOUT=64).
module tb_sram_arbiter;
    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   outstanding = 0;

    typedef struct {
        bit          b;
        int          at;
        bit          rd;
        logic [15:0] data;
        bit          err;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    sram_arbiter_if bus();

    sram_arbiter #(.WR_CYCLES(4), .RD_TIMEOUT(64)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input bit b, input int at, input bit rd, input logic [15:0] data, input bit err);
        exp_t x;
        x.b = b;
        x.at = at;
        x.rd = rd;
        x.data = data;
        x.err = err;
        exp_q.push_back(x);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_outs();
        check("rst_ctrl", {bus.ack_a, bus.ack_b, bus.err, bus.busy, bus.valid_request, bus.write}, 0);
        check("rst_addr", bus.address, 0);
        check("rst_wdata", bus.wdata, 0);
        check("rst_rdata", bus.rdata, 0);
    endtask

    task automatic set_req(input bit b, input bit wr, input logic [21:0] addr, input logic [15:0] data);
        if (b) begin
            bus.write_b = wr; bus.addr_b = addr; bus.wdata_b = data; bus.req_b = 1'b1;
        end else begin
            bus.write_a = wr; bus.addr_a = addr; bus.wdata_a = data; bus.req_a = 1'b1;
        end
    endtask

    // Registered requester: it keeps req high for n acks and drops it on the edge that ends the last ack cycle.
    task automatic port_run(input bit b, input int n);
        int got = 0;
        int budget = 0;
        while (got < n && budget < 200) begin
            @(negedge clk);
            budget++;
            if (b ? bus.ack_b : bus.ack_a) got++;
        end
        @(posedge clk);
        #1;
        if (b) bus.req_b = 1'b0; else bus.req_a = 1'b0;
        check(b ? "ack_wait_b" : "ack_wait_a", got, n);
    endtask

    // SRAM controller model: it strobes valid_read with data for exactly the given cycle.
    task automatic sram_pulse(input int at, input logic [15:0] d);
        while (cyc < at) begin
            @(posedge clk);
            #1;
        end
        bus.sram_rdata = d;
        bus.valid_read = 1'b1;
        @(posedge clk);
        #1;
        bus.valid_read = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst_n) outstanding = 0;
        else begin
            if (bus.valid_request) begin
                check("vr_overlap", outstanding, 0);
                check("vr_busy", bus.busy, 1);
                outstanding++;
            end
            if (bus.ack_a || bus.ack_b) begin
                if (outstanding > 0) outstanding--;
                check("ack_both", bus.ack_a & bus.ack_b, 0);
                if (exp_q.size() == 0) check("ack_unexpected", {bus.ack_a, bus.ack_b}, 0);
                else begin
                    e = exp_q.pop_front();
                    check("ack_port", bus.ack_b, e.b);
                    check("ack_cycle", cyc, e.at);
                    if (e.rd) check("rdata", bus.rdata, e.data);
                    check("err", bus.err, e.err);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst_n = 1'b0;
        bus.req_a = 0; bus.write_a = 0; bus.addr_a = 0; bus.wdata_a = 0;
        bus.req_b = 0; bus.write_b = 0; bus.addr_b = 0; bus.wdata_b = 0;
        bus.sram_rdata = 0; bus.valid_read = 0;
        tick(2);
        @(negedge clk);
        reset_outs();
        tick(1);
        rst_n = 1'b1;
        tick(2);

        // A single write from A, with the issue cycle checked directly.
        c0 = cyc;
        set_req(0, 1, 22'h000123, 16'hBEEF);
        push(0, c0 + 6, 0, 16'h0, 0);
        @(negedge clk);
        @(negedge clk);
        check("issue_vr", bus.valid_request, 1);
        check("issue_addr", bus.address, 22'h000123);
        check("issue_wdata", bus.wdata, 16'hBEEF);
        check("issue_write", bus.write, 1);
        port_run(0, 1);

        // A read from B, answered by the SRAM in cycle 5.
        c0 = cyc;
        set_req(1, 0, 22'h3FFFFF, 16'h0);
        push(1, c0 + 6, 1, 16'hA5A5, 0);
        fork
            sram_pulse(c0 + 5, 16'hA5A5);
            port_run(1, 1);
        join

        // Both ports request continuously, so the grants must alternate A, B, A, B.
        c0 = cyc;
        set_req(0, 1, 22'h000010, 16'h1111);
        set_req(1, 1, 22'h000020, 16'h2222);
        push(0, c0 + 6, 0, 0, 0);
        push(1, c0 + 13, 0, 0, 0);
        push(0, c0 + 20, 0, 0, 0);
        push(1, c0 + 27, 0, 0, 0);
        fork
            port_run(0, 2);
            port_run(1, 2);
        join

        // A read timeout, followed by a late valid_read that arrives in IDLE.
        c0 = cyc;
        set_req(0, 0, 22'h001000, 16'h0);
        push(0, c0 + 66, 1, 16'h0000, 1);
        port_run(0, 1);
        sram_pulse(c0 + 68, 16'hDEAD);
        @(negedge clk);
        check("late_vr_busy", bus.busy, 0);

        // valid_read arrives in the same cycle as the timeout.
        c0 = cyc;
        set_req(0, 0, 22'h002000, 16'h0);
        push(0, c0 + 66, 1, 16'h1234, 0);
        fork
            sram_pulse(c0 + 65, 16'h1234);
            port_run(0, 1);
        join

        // Reset is asserted during WAIT_WR, and the transaction is abandoned.
        c0 = cyc;
        set_req(0, 1, 22'h000777, 16'h7777);
        tick(3);
        rst_n = 1'b0;
        bus.req_a = 1'b0;
        #1;
        reset_outs();
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // A and B tie after the reset, so A wins; B is served next.
        c0 = cyc;
        set_req(0, 0, 22'h000042, 16'h0);
        set_req(1, 1, 22'h000043, 16'h4343);
        push(0, c0 + 4, 1, 16'h5A5A, 0);
        push(1, c0 + 11, 0, 0, 0);
        fork
            sram_pulse(c0 + 3, 16'h5A5A);
            port_run(0, 1);
            port_run(1, 1);
        join
        tick(3);

        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter and sequencer for the shared SRAM controller request interface. It accepts single-word read/write requests from two requesters: port A, the memory controller loading scene data over UART, and port B, the raster/framebuffer writer. It grants them round-robin and drives one transaction at a time into the SRAM controller. It tracks read completion, with a timeout, and write completion, with a fixed-latency counter, and returns a one-cycle acknowledge to the granted requester.

## Interface
- WR_CYCLES, 4: cycles from write issue to write completion; legal range 1..255.
- RD_TIMEOUT, 64: maximum cycles spent waiting for iValidRead before an error response; legal range 2..255.
- iClock  in  1  system clock; all logic on rising edge.
- iReset  in  1  asynchronous, active-low reset.
- iReqA / iReqB  in  1  request; held high with stable attributes until the matching oAck.
- iWriteA / iWriteB  in  1  1 = write, 0 = read.
- iAddrA / iAddrB  in  22  word address.
- iWDataA / iWDataB  in  16  write data.
- oAckA / oAckB  out  1  one-cycle completion pulse.
- oRData  out  16  read data; valid while oAckA or oAckB is high.
- oErr  out  1  high with an ack when a read timed out.
- oBusy  out  1  high whenever the state is not IDLE.
- oAddress  out  22  to SRAM controller iAddress.
- oWData  out  16  to SRAM controller write data; an external tristate wrapper drives the inout bus.
- oValidRequest  out  1  one-cycle request strobe to the SRAM controller.
- oWrite  out  1  transaction type to the SRAM controller.
- iRData  in  16  read data from the SRAM controller.
- iValidRead  in  1  SRAM controller read-complete strobe; iRData is valid in the same cycle.

## Operation
- States:
  - IDLE: evaluate requests.
  - ISSUE: drive oValidRequest.
  - WAIT_RD: wait for iValidRead or timeout.
  - WAIT_WR: count the write latency.
  - RESP: drive the ack for one cycle.
- IDLE:
  - No request: stay in IDLE.
  - Only one requester high: grant it.
  - Both high: grant the port not granted last (round-robin). The last-grant pointer resets to B, so A wins the first tie.
- On grant:
  - Latch write, address and data of the granted port into internal registers.
  - Record the granted port.
  - Update the last-grant pointer.
  - Go to ISSUE.
- ISSUE:
  - oValidRequest=1 for exactly one cycle.
  - oAddress, oWrite and oWData come from the latched registers, and hold from ISSUE through RESP.
  - Next state is WAIT_WR for a write, WAIT_RD for a read.
  - The wait counter clears to 0.
- WAIT_RD:
  - The counter increments every cycle.
  - If iValidRead=1, capture iRData into the rdata register, set err=0, go to RESP.
  - Otherwise, when the counter reaches RD_TIMEOUT-1, set rdata=0, err=1, go to RESP.
  - iValidRead has priority if it coincides with the timeout cycle.
- WAIT_WR:
  - The counter increments every cycle.
  - When the counter reaches WR_CYCLES-1, go to RESP with err=0.
- RESP:
  - Assert the granted port's oAck for one cycle.
  - oRData and oErr are registered values, meaningful only in this cycle.
  - The next state is IDLE.
- iValidRead outside WAIT_RD is ignored.
- Request changes on a non-granted port never disturb an in-flight transaction.
- A requester dropping iReq mid-transaction does not abort it; the ack is still generated.
- The requester must deassert iReq on the edge where it samples oAck (registered requester). IDLE in the following cycle therefore sees only genuine new requests.
- Counters are 8 bits wide, with no wrap in legal parameter ranges.

## Timing
- Reset (iReset=0, asynchronous):
  - State IDLE, last-grant pointer at B.
  - All outputs 0: oAckA, oAckB, oErr, oBusy, oValidRequest, oWrite, oAddress, oWData, oRData.
  - Reset mid-transaction abandons it with no ack.
- Cycle numbering takes the IDLE cycle with the request high as cycle 0. oValidRequest is high in cycle 1.
- Write: oAck is high in cycle WR_CYCLES+2, and IDLE resumes in cycle WR_CYCLES+3.
- Read: if iValidRead is high in cycle k (k≥2), oAck is high in cycle k+1.
- Read timeout: oAck and oErr are high in cycle RD_TIMEOUT+2.
- Back-to-back throughput: minimum 4 cycles per read, WR_CYCLES+3 cycles per write.
- oBusy is high from cycle 1 through the RESP cycle inclusive.

## Test plan
- Reset, then a single A write: addr 0x000123, data 0xBEEF, WR_CYCLES=4.
  - oValidRequest in cycle 1 with oAddress=0x000123, oWData=0xBEEF, oWrite=1.
  - oAckA in cycle 6, oErr=0.
- B read of 0x3FFFFF, SRAM model returns 0xA5A5 with iValidRead in cycle 5.
  - oAckB in cycle 6 with oRData=0xA5A5, oErr=0.
- iReqA and iReqB both high continuously after reset, 4 transactions.
  - Grant order A, B, A, B; exactly one ack per transaction.
  - oValidRequest pulses never overlap a busy transaction.
- Read with no iValidRead, RD_TIMEOUT=64.
  - oAck and oErr=1 in cycle 66, oRData=0x0000.
  - A late iValidRead arriving in IDLE is ignored.
- iValidRead coincident with the timeout cycle, data 0x1234.
  - Response oRData=0x1234, oErr=0.
- iReset asserted during WAIT_WR.
  - All outputs 0 immediately, no ack.
  - After release, a new A read completes normally, with A winning a tie.
